regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//   Next-generation integer register file for the RISC-V core: parametrised width/depth, N async
//   read ports, M sync write ports, per-register busy scoreboard for in-flight producers.
//   Sits between decode (reads, issue) and writeback (writes); x0 hardwired to zero.
// PARAMETERS
//   XLEN      32  data width of each register
//   NUM_REGS  32  register count (power of 2, >=2); index 0 is hardwired zero
//   NUM_RD    3   read ports
//   NUM_WR    2   write ports; higher port index has priority
//   ADDR_W    $clog2(NUM_REGS)  register address width (derived, do not override)
// PORTS
//   clk         in   1              clock, all state on rising edge
//   reset       in   1              asynchronous, active-low; clears all state
//   rd_addr     in   NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data     out  NUM_RD*XLEN    read data, port p at [p*XLEN +: XLEN]
//   rd_busy     out  NUM_RD         1 = addressed reg has pending producer
//   wr_en       in   NUM_WR         write enable per port
//   wr_addr     in   NUM_WR*ADDR_W  write addresses
//   wr_data     in   NUM_WR*XLEN    write data
//   iss_en      in   1              issue: mark iss_addr busy
//   iss_addr    in   ADDR_W         destination of issued instruction
//   busy_vec    out  NUM_REGS       full scoreboard, bit i = reg i busy
// BEHAVIOUR
//   - Reset (reset==0, async): all regs <= 0, busy_vec <= 0; rd_data = 0, rd_busy = 0 while held.
//   - Read: combinational, zero latency; rd_addr==0 -> rd_data=0, rd_busy=0 always.
//   - Write: registered on posedge clk when wr_en[w] && wr_addr!=0; visible on reads next cycle.
//   - Same-address multi-write in one cycle: highest-index enabled port wins; others dropped.
//   - Write to 0 ignored: no data change, no busy change.
//   - Scoreboard: iss_en && iss_addr!=0 sets busy[iss_addr]; any enabled write clears busy[wr_addr].
//   - Set and clear same reg same cycle: set wins (new producer supersedes retiring one).
//   - Clear of a non-busy reg: data written, busy stays 0 (no error).
//   - Reset asserted mid-operation: pending write that edge is discarded; state is reset values.
//   - No overflow/wrap cases: busy is one bit per reg; re-issue to busy reg keeps busy=1.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: same-cycle write->read forwarding; if any wr_en[w] targets
//     rd_addr[p] (!=0), rd_data[p] = winning wr_data (priority as above) and rd_busy[p]=0
//     unless iss_en targets the same reg that cycle.
//   Undefined: reads return stored value only; written data visible the cycle after the write.
// STRUCTURE
//   regfile_pkg: XLEN/NUM_REGS defaults, reg_addr_t typedef, REG_ZERO constant.
//   Sub-module regfile_scoreboard: busy_vec state, set/clear/priority logic; top instantiates it
//   plus the storage array, write-priority mux and optional bypass mux.
// TESTING
//   1 reset low mid-run after writes -> every rd_data=0, busy_vec=0; release -> still 0 until written.
//   2 wr_en=2'b01 addr5 data 0xDEADBEEF -> rd_addr=5 reads 0xDEADBEEF next cycle; write to 0 -> reads 0.
//   3 both ports write reg7 (p0=0x11, p1=0x22) -> reg7=0x22.
//   4 iss reg9 -> busy_vec[9]=1, rd_busy=1; wr reg9 -> busy 0; iss+wr reg9 same cycle -> busy stays 1.
//   5 BYPASS_EN: write reg3=0xA5A5 and read reg3 same cycle -> 0xA5A5 same cycle; without macro -> old value.
//   6 Random: issue/write/read streams vs. reference model, NUM_RD=4, NUM_WR=3, NUM_REGS=64, XLEN=64.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and address type for the multi-port integer register file.
// Same-cycle write->read forwarding is enabled with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 3;
    localparam int DEF_NUM_WR   = 2;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, any enabled write clears, set beats clear.
// Register 0 never becomes busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic [NUM_REGS-1:0]      busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clears are applied first so a same-cycle issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] != '0)) begin
                busy_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_en_i && (iss_addr_i != '0)) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_multiport.sv
// Integer register file: NUM_RD async read ports, NUM_WR sync write ports, busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk_i      (clk),
        .rst_ni     (reset),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .busy_o     (busy_vec)
    );

    // Ascending port order lets the highest-index writer overwrite lower ones.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] != '0)) begin
                regs_d[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p*XLEN +: XLEN] = regs_q[rd_addr[p*ADDR_W +: ADDR_W]];
            rd_busy[p]              = busy_vec[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed while reset is held so reads stay zero.
            if (reset) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])) begin
                        rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                        rd_busy[p] = iss_en && (iss_addr == rd_addr[p*ADDR_W +: ADDR_W]);
                    end
                end
            end
`endif
            if (rd_addr[p*ADDR_W +: ADDR_W] == '0) begin
                rd_data[p*XLEN +: XLEN] = '0;
                rd_busy[p]              = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport (default shape) plus a randomised stream on a
// 64x64-bit, 4-read/3-write instance checked against a reference model.
module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    // Instance A: default parameters
    logic [14:0] a_rd_addr;
    logic [95:0] a_rd_data;
    logic [2:0]  a_rd_busy;
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_iss_en;
    logic [4:0]  a_iss_addr;
    logic [31:0] a_busy_vec;

    // Instance B: wide configuration
    logic [23:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic [2:0]   b_wr_en;
    logic [17:0]  b_wr_addr;
    logic [191:0] b_wr_data;
    logic         b_iss_en;
    logic [5:0]   b_iss_addr;
    logic [63:0]  b_busy_vec;

    regfile_multiport u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (a_rd_addr),
        .rd_data  (a_rd_data),
        .rd_busy  (a_rd_busy),
        .wr_en    (a_wr_en),
        .wr_addr  (a_wr_addr),
        .wr_data  (a_wr_data),
        .iss_en   (a_iss_en),
        .iss_addr (a_iss_addr),
        .busy_vec (a_busy_vec)
    );

    regfile_multiport #(
        .XLEN     (64),
        .NUM_REGS (64),
        .NUM_RD   (4),
        .NUM_WR   (3)
    ) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .rd_busy  (b_rd_busy),
        .wr_en    (b_wr_en),
        .wr_addr  (b_wr_addr),
        .wr_data  (b_wr_data),
        .iss_en   (b_iss_en),
        .iss_addr (b_iss_addr),
        .busy_vec (b_busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle;
        a_wr_en  = '0;
        a_iss_en = 1'b0;
    endtask

    task automatic a_wr(input int p, input logic [4:0] addr, input logic [31:0] data);
        a_wr_en[p]            = 1'b1;
        a_wr_addr[p*5 +: 5]   = addr;
        a_wr_data[p*32 +: 32] = data;
    endtask

    task automatic a_iss(input logic [4:0] addr);
        a_iss_en   = 1'b1;
        a_iss_addr = addr;
    endtask

    task automatic a_set_rd(input int p, input logic [4:0] addr);
        a_rd_addr[p*5 +: 5] = addr;
    endtask

    function automatic logic [31:0] a_rdata(input int p);
        return a_rd_data[p*32 +: 32];
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset;
        #2;
        checks++;
        if (a_busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL reset_busy_vec: got %0h expected 0", a_busy_vec);
        end
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (a_rdata(p) !== 32'h0 || a_rd_busy[p] !== 1'b0) begin
                errors++;
                $display("FAIL reset_read p%0d: got data %0h busy %0b expected 0/0", p, a_rdata(p), a_rd_busy[p]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write;
        a_idle();
        a_wr(0, 5'd5, 32'hDEAD_BEEF);
        a_set_rd(0, 5'd5);
        #2;
        checks++;
        if (a_rdata(0) !== (BYP ? 32'hDEAD_BEEF : 32'h0)) begin
            errors++;
            $display("FAIL write_same_cycle: got %0h expected %0h", a_rdata(0), BYP ? 32'hDEAD_BEEF : 32'h0);
        end
        tick();
        a_idle();
        #2;
        checks++;
        if (a_rdata(0) !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_next_cycle: got %0h expected deadbeef", a_rdata(0));
        end
        a_wr(1, 5'd0, 32'h1234_5678);
        a_set_rd(1, 5'd0);
        #2;
        checks++;
        if (a_rdata(1) !== 32'h0) begin
            errors++;
            $display("FAIL write_x0_same_cycle: got %0h expected 0", a_rdata(1));
        end
        tick();
        a_idle();
        #2;
        checks++;
        if (a_rdata(1) !== 32'h0 || a_busy_vec !== 32'h0 || a_rdata(0) !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_x0: got x0 %0h busy %0h r5 %0h expected 0/0/deadbeef", a_rdata(1), a_busy_vec, a_rdata(0));
        end
    endtask

    task automatic test_priority;
        a_wr(0, 5'd7, 32'h11);
        a_wr(1, 5'd7, 32'h22);
        a_set_rd(0, 5'd7);
        #2;
        checks++;
        if (a_rdata(0) !== (BYP ? 32'h22 : 32'h0)) begin
            errors++;
            $display("FAIL prio_same_cycle: got %0h expected %0h", a_rdata(0), BYP ? 32'h22 : 32'h0);
        end
        tick();
        a_idle();
        #2;
        checks++;
        if (a_rdata(0) !== 32'h22) begin
            errors++;
            $display("FAIL prio_reg7: got %0h expected 22", a_rdata(0));
        end
        a_wr(0, 5'd8, 32'h33);
        a_wr(1, 5'd10, 32'h44);
        tick();
        a_idle();
        a_set_rd(0, 5'd8);
        a_set_rd(1, 5'd10);
        #2;
        checks++;
        if (a_rdata(0) !== 32'h33 || a_rdata(1) !== 32'h44) begin
            errors++;
            $display("FAIL dual_write: got %0h/%0h expected 33/44", a_rdata(0), a_rdata(1));
        end
    endtask

    task automatic test_scoreboard;
        a_set_rd(0, 5'd9);
        a_iss(5'd9);
        tick();
        a_idle();
        #2;
        checks++;
        if (a_busy_vec !== 32'h200 || a_rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL iss_set: got busy %0h rd_busy %0b expected 200/1", a_busy_vec, a_rd_busy[0]);
        end
        a_wr(0, 5'd9, 32'h99);
        #2;
        checks++;
        if (a_rd_busy[0] !== !BYP || a_rdata(0) !== (BYP ? 32'h99 : 32'h0)) begin
            errors++;
            $display("FAIL retire_same_cycle: got %0h busy %0b expected %0h busy %0b",
                     a_rdata(0), a_rd_busy[0], BYP ? 32'h99 : 32'h0, !BYP);
        end
        tick();
        a_idle();
        #2;
        checks++;
        if (a_busy_vec !== 32'h0 || a_rdata(0) !== 32'h99) begin
            errors++;
            $display("FAIL wr_clear: got busy %0h data %0h expected 0/99", a_busy_vec, a_rdata(0));
        end
        a_iss(5'd9);
        tick();
        a_iss(5'd9);
        a_wr(1, 5'd9, 32'hAB);
        #2;
        checks++;
        if (a_rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL set_clear_comb: got rd_busy %0b expected 1", a_rd_busy[0]);
        end
        tick();
        a_idle();
        #2;
        checks++;
        if (a_busy_vec !== 32'h200 || a_rdata(0) !== 32'hAB || a_rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: got busy %0h data %0h rd_busy %0b expected 200/ab/1", a_busy_vec, a_rdata(0), a_rd_busy[0]);
        end
        a_iss(5'd9);
        tick();
        a_idle();
        a_wr(0, 5'd11, 32'hCC);
        a_iss(5'd0);
        a_set_rd(1, 5'd11);
        tick();
        a_idle();
        #2;
        checks++;
        if (a_busy_vec !== 32'h200 || a_rdata(1) !== 32'hCC || a_rd_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL reissue_nonbusy_clear_x0: got busy %0h r11 %0h expected 200/cc", a_busy_vec, a_rdata(1));
        end
        a_iss(5'd12);
        a_wr(0, 5'd9, 32'h9A);
        tick();
        a_idle();
        #2;
        checks++;
        if (a_busy_vec !== 32'h1000) begin
            errors++;
            $display("FAIL iss12_clr9: got %0h expected 1000", a_busy_vec);
        end
        a_wr(1, 5'd12, 32'h12);
        tick();
        a_idle();
        #2;
        checks++;
        if (a_busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL clr12: got %0h expected 0", a_busy_vec);
        end
    endtask

    task automatic test_bypass;
        a_wr(0, 5'd3, 32'h5A5A);
        tick();
        a_idle();
        a_iss(5'd3);
        tick();
        a_idle();
        a_wr(0, 5'd3, 32'h1111);
        a_wr(1, 5'd3, 32'hA5A5);
        a_set_rd(2, 5'd3);
        #2;
        checks++;
        if (a_rdata(2) !== (BYP ? 32'hA5A5 : 32'h5A5A) || a_rd_busy[2] !== !BYP) begin
            errors++;
            $display("FAIL bypass_read: got %0h busy %0b expected %0h busy %0b",
                     a_rdata(2), a_rd_busy[2], BYP ? 32'hA5A5 : 32'h5A5A, !BYP);
        end
        tick();
        a_idle();
        #2;
        checks++;
        if (a_rdata(2) !== 32'hA5A5 || a_rd_busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_after: got %0h busy %0b expected a5a5/0", a_rdata(2), a_rd_busy[2]);
        end
    endtask

    task automatic test_reset_mid;
        a_iss(5'd6);
        tick();
        a_idle();
        a_wr(0, 5'd5, 32'hFFFF);
        a_set_rd(0, 5'd5);
        a_set_rd(1, 5'd7);
        a_set_rd(2, 5'd6);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (a_rd_data !== 96'h0 || a_rd_busy !== 3'b0 || a_busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_async: got data %0h rd_busy %0b busy %0h expected 0", a_rd_data, a_rd_busy, a_busy_vec);
        end
        tick();
        checks++;
        if (a_rd_data !== 96'h0 || a_busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_edge: got data %0h busy %0h expected 0", a_rd_data, a_busy_vec);
        end
        a_idle();
        reset = 1'b1;
        tick();
        #2;
        checks++;
        if (a_rd_data !== 96'h0 || a_busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: got data %0h busy %0h expected 0", a_rd_data, a_busy_vec);
        end
        a_wr(1, 5'd5, 32'h55);
        tick();
        a_idle();
        #2;
        checks++;
        if (a_rdata(0) !== 32'h55) begin
            errors++;
            $display("FAIL reset_recover: got %0h expected 55", a_rdata(0));
        end
    endtask

    task automatic test_random;
        logic [63:0] m_regs [64];
        logic [63:0] m_busy;
        logic [5:0]  ra;
        logic [5:0]  wa;
        logic [63:0] exp_d;
        logic        exp_b;
        for (int i = 0; i < 64; i++) m_regs[i] = '0;
        m_busy = '0;
        for (int c = 0; c < 300; c++) begin
            b_iss_en   = ($urandom_range(0, 1) == 1);
            b_iss_addr = 6'($urandom_range(0, 7));
            for (int w = 0; w < 3; w++) begin
                b_wr_en[w]            = ($urandom_range(0, 2) == 0);
                b_wr_addr[w*6 +: 6]   = 6'($urandom_range(0, 7));
                b_wr_data[w*64 +: 64] = {$urandom(), $urandom()};
            end
            for (int p = 0; p < 4; p++) b_rd_addr[p*6 +: 6] = 6'($urandom_range(0, 7));
            #2;
            for (int p = 0; p < 4; p++) begin
                ra    = b_rd_addr[p*6 +: 6];
                exp_d = m_regs[ra];
                exp_b = m_busy[ra];
                if (BYP) begin
                    for (int w = 0; w < 3; w++) begin
                        if (b_wr_en[w] && b_wr_addr[w*6 +: 6] == ra) begin
                            exp_d = b_wr_data[w*64 +: 64];
                            exp_b = b_iss_en && (b_iss_addr == ra);
                        end
                    end
                end
                if (ra == 6'd0) begin
                    exp_d = '0;
                    exp_b = 1'b0;
                end
                checks++;
                if (b_rd_data[p*64 +: 64] !== exp_d || b_rd_busy[p] !== exp_b) begin
                    errors++;
                    $display("FAIL random_read c%0d p%0d r%0d: got %0h busy %0b expected %0h busy %0b",
                             c, p, ra, b_rd_data[p*64 +: 64], b_rd_busy[p], exp_d, exp_b);
                end
            end
            checks++;
            if (b_busy_vec !== m_busy) begin
                errors++;
                $display("FAIL random_busy c%0d: got %0h expected %0h", c, b_busy_vec, m_busy);
            end
            for (int w = 0; w < 3; w++) begin
                wa = b_wr_addr[w*6 +: 6];
                if (b_wr_en[w] && wa != 6'd0) begin
                    m_regs[wa] = b_wr_data[w*64 +: 64];
                    m_busy[wa] = 1'b0;
                end
            end
            if (b_iss_en && b_iss_addr != 6'd0) m_busy[b_iss_addr] = 1'b1;
            tick();
        end
        b_wr_en  = '0;
        b_iss_en = 1'b0;
        #2;
        checks++;
        if (b_busy_vec !== m_busy) begin
            errors++;
            $display("FAIL random_busy_final: got %0h expected %0h", b_busy_vec, m_busy);
        end
    endtask

    initial begin
        reset      = 1'b0;
        a_rd_addr  = {5'd3, 5'd2, 5'd1};
        a_wr_en    = '0;
        a_wr_addr  = '0;
        a_wr_data  = '0;
        a_iss_en   = 1'b0;
        a_iss_addr = '0;
        b_rd_addr  = '0;
        b_wr_en    = '0;
        b_wr_addr  = '0;
        b_wr_data  = '0;
        b_iss_en   = 1'b0;
        b_iss_addr = '0;

        test_reset();
        test_write();
        test_priority();
        test_scoreboard();
        test_bypass();
        test_reset_mid();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
